// File: rtl/rr_bus_arbiter_if.sv
// rtl/rr_bus_arbiter_if.sv - request/grant bundle between bus masters and the arbiter
interface rr_bus_arbiter_if #(
   parameter int NUM_REQUESTERS = 2
) ();
   localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

   logic [NUM_REQUESTERS-1:0] i_requests;
   logic                      i_done;
   logic [NUM_REQUESTERS-1:0] o_grants;
   logic                      o_grant_valid;
   logic [IW-1:0]             o_grant_index;
   logic                      o_timeout;

   modport master (
      output i_requests, i_done,
      input  o_grants, o_grant_valid, o_grant_index, o_timeout
   );

   modport slave (
      input  i_requests, i_done,
      output o_grants, o_grant_valid, o_grant_index, o_timeout
   );
endinterface

// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - round-robin bus arbiter with turnaround gap and tenure hold limit
module rr_bus_arbiter #(
   parameter int NUM_REQUESTERS  = 2,
   parameter int MAX_HOLD_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   rr_bus_arbiter_if.slave    bus
);
   localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam int HW = (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
   localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQUESTERS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t                    state_q, state_d;
   logic [NUM_REQUESTERS-1:0] grants_q, grants_d;
   logic [IW-1:0]             index_q, index_d;
   logic [IW-1:0]             last_q, last_d;
   logic [HW-1:0]             hold_q, hold_d;
   logic                      timeout_q, timeout_d;

   logic                      win_found;
   logic [IW-1:0]             win_idx;
   logic [IW-1:0]             cand_idx;
   logic                      limit_hit;
   logic                      owner_req;

   // Search starts one past the previous owner and wraps, so every master gets a turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM_REQUESTERS; k++) begin
         cand_idx = IW'((int'(last_q) + k) % NUM_REQUESTERS);
         if (!win_found && bus.i_requests[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   assign limit_hit = (MAX_HOLD_CYCLES > 0) && (hold_q == HOLD_LAST);
   assign owner_req = bus.i_requests[index_q];

   always_comb begin
      state_d   = state_q;
      grants_d  = grants_q;
      index_d   = index_q;
      last_d    = last_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE, GAP: begin
            hold_d = '0;
            if (win_found) begin
               state_d           = GRANT;
               grants_d          = '0;
               grants_d[win_idx] = 1'b1;
               index_d           = win_idx;
               last_d            = win_idx;
            end else begin
               state_d  = IDLE;
               grants_d = '0;
               index_d  = '0;
            end
         end
         GRANT: begin
            // A normal release wins over the hold limit, so no timeout is flagged then.
            if (bus.i_done || !owner_req) begin
               state_d  = GAP;
               grants_d = '0;
               index_d  = '0;
            end else if (limit_hit) begin
               state_d   = GAP;
               grants_d  = '0;
               index_d   = '0;
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            grants_d = '0;
            index_d  = '0;
            hold_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grants_q  <= '0;
         index_q   <= '0;
         last_q    <= LAST_RST;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grants_q  <= grants_d;
         index_q   <= index_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.o_grants      = grants_q;
   assign bus.o_grant_valid = |grants_q;
   assign bus.o_grant_index = index_q;
   assign bus.o_timeout     = timeout_q;
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - scoreboard bench for rr_bus_arbiter in 2- and 4-master configurations
module tb_rr_bus_arbiter;
   logic clk = 1'b0;
   logic a_rst_n;
   logic b_rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   fin_req = 1'b0;
   bit   fin_ack = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rr_bus_arbiter_if #(.NUM_REQUESTERS(2)) a_if ();
   rr_bus_arbiter_if #(.NUM_REQUESTERS(4)) b_if ();

   rr_bus_arbiter #(.NUM_REQUESTERS(2), .MAX_HOLD_CYCLES(16)) dut_a (
      .clk   (clk),
      .rst_n (a_rst_n),
      .bus   (a_if)
   );

   rr_bus_arbiter #(.NUM_REQUESTERS(4), .MAX_HOLD_CYCLES(4)) dut_b (
      .clk   (clk),
      .rst_n (b_rst_n),
      .bus   (b_if)
   );

   typedef struct {
      int         cyc;
      bit         d;
      logic [3:0] g;
      logic       to;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   logic [7:0] mon_act;
   logic [7:0] mon_exp;

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   task automatic push(input bit d, input logic [3:0] g, input logic to, input string nm);
      exp_t e;
      e.cyc = cyc + 1;
      e.d   = d;
      e.g   = g;
      e.to  = to;
      e.nm  = nm;
      exp_q.push_back(e);
   endtask

   task automatic step(input bit d, input logic [3:0] req, input logic done, input logic rstn,
                       input logic [3:0] eg, input logic eto, input string nm);
      if (!d) begin
         a_if.i_requests = req[1:0];
         a_if.i_done     = done;
         a_rst_n         = rstn;
      end else begin
         b_if.i_requests = req;
         b_if.i_done     = done;
         b_rst_n         = rstn;
      end
      push(d, eg, eto, nm);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         if (mon_e.d)
            mon_act = {b_if.o_grants, b_if.o_grant_valid, b_if.o_grant_index, b_if.o_timeout};
         else
            mon_act = {2'b00, a_if.o_grants, a_if.o_grant_valid, 1'b0, a_if.o_grant_index, a_if.o_timeout};
         mon_exp = {mon_e.g, |mon_e.g, idx_of(mon_e.g), mon_e.to};
         checks++;
         if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL %s cyc=%0d grants/valid/index/timeout got %b expected %b",
                     mon_e.nm, cyc, mon_act, mon_exp);
         end
      end
      if (fin_req && !fin_ack) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d expected 0", exp_q.size());
         end
         fin_ack = 1'b1;
      end
   end

   initial begin
      a_rst_n = 1'b0;
      b_rst_n = 1'b0;
      a_if.i_requests = '0;
      a_if.i_done     = 1'b0;
      b_if.i_requests = '0;
      b_if.i_done     = 1'b0;
      @(posedge clk);
      #1;
      push(1'b0, 4'b0000, 1'b0, "a_reset");
      push(1'b1, 4'b0000, 1'b0, "b_reset");
      @(posedge clk);
      #1;
      b_rst_n = 1'b1;

      // 2 masters, hold limit 16
      step(0, 4'b0011, 0, 1, 4'b0001, 0, "a_first_m0");
      step(0, 4'b0011, 0, 1, 4'b0001, 0, "a_hold_other_req");
      step(0, 4'b0011, 1, 1, 4'b0000, 0, "a_done_gap");
      step(0, 4'b0011, 0, 1, 4'b0010, 0, "a_rr_m1");
      step(0, 4'b0001, 0, 1, 4'b0000, 0, "a_drop_gap");
      step(0, 4'b0001, 0, 1, 4'b0001, 0, "a_m0_again");
      step(0, 4'b0001, 1, 1, 4'b0000, 0, "a_done_gap2");
      step(0, 4'b0001, 0, 1, 4'b0001, 0, "a_single_regrant");
      step(0, 4'b0000, 1, 1, 4'b0000, 0, "a_release_gap");
      step(0, 4'b0000, 1, 1, 4'b0000, 0, "a_idle_done_ignored");
      step(0, 4'b0010, 0, 1, 4'b0010, 0, "a_grant_m1");
      step(0, 4'b0011, 0, 1, 4'b0010, 0, "a_m1_hold");
      step(0, 4'b0011, 0, 0, 4'b0000, 0, "a_reset_in_grant");
      step(0, 4'b0011, 0, 1, 4'b0001, 0, "a_after_reset_m0");
      step(0, 4'b0000, 0, 1, 4'b0000, 0, "a_final_gap");

      // 4 masters, hold limit 4
      step(1, 4'b0000, 0, 1, 4'b0000, 0, "b_idle_start");
      step(1, 4'b0100, 0, 1, 4'b0100, 0, "b_hold1");
      step(1, 4'b0100, 0, 1, 4'b0100, 0, "b_hold2");
      step(1, 4'b0100, 0, 1, 4'b0100, 0, "b_hold3");
      step(1, 4'b0100, 0, 1, 4'b0100, 0, "b_hold4");
      step(1, 4'b0100, 0, 1, 4'b0000, 1, "b_timeout_gap");
      step(1, 4'b0100, 0, 1, 4'b0100, 0, "b_regrant_m2");
      step(1, 4'b0100, 0, 1, 4'b0100, 0, "b_t2");
      step(1, 4'b0100, 0, 1, 4'b0100, 0, "b_t3");
      step(1, 4'b0100, 0, 1, 4'b0100, 0, "b_t4");
      step(1, 4'b0100, 1, 1, 4'b0000, 0, "b_done_and_limit");
      step(1, 4'b1000, 0, 1, 4'b1000, 0, "b_grant_m3");
      step(1, 4'b1000, 0, 1, 4'b1000, 0, "b_m3_hold");
      step(1, 4'b1011, 1, 1, 4'b0000, 0, "b_m3_release");
      step(1, 4'b1011, 0, 1, 4'b0001, 0, "b_wrap_m0");
      step(1, 4'b1011, 1, 1, 4'b0000, 0, "b_m0_release");
      step(1, 4'b1011, 0, 1, 4'b0010, 0, "b_rot_m1");
      step(1, 4'b1011, 1, 1, 4'b0000, 0, "b_m1_release");
      step(1, 4'b1011, 0, 1, 4'b1000, 0, "b_rot_m3");
      step(1, 4'b1011, 0, 1, 4'b1000, 0, "b_m3_hold2");
      step(1, 4'b0011, 0, 1, 4'b0000, 0, "b_drop_gap");
      step(1, 4'b0011, 0, 1, 4'b0001, 0, "b_after_drop_m0");
      step(1, 4'b0000, 0, 1, 4'b0000, 0, "b_drop_gap2");
      step(1, 4'b0000, 0, 1, 4'b0000, 0, "b_idle_end");

      fin_req = 1'b1;
      for (int i = 0; i < 10 && !fin_ack; i++) @(posedge clk);
      if (!fin_ack) begin
         $display("FAIL finish_handshake ack got 0 expected 1");
         $fatal(1, "monitor did not complete");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
